onehot_addr_sequencer: RTL
==========================

// Module: onehot_addr_sequencer
// PURPOSE
//  Parametrised one-hot write-address sequencer for WriteReg banks in the CNN layers.
//  - Walks a single hot bit around an N-bit ring, in either direction.
//  - Counts complete passes and reports done after PASSES rotations.
//  - Exposes a binary index and a wrap pulse, so downstream writers can gate frame writes.
// PARAMETERS
//  N       15  ring width = number of write addresses; N >= 2
//  PASSES  1   full rotations per run before done; 1..255
//  IDXW    4   binary index width; 2**IDXW >= N
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       reset, asynchronous, active-low
//  clr       in   1       synchronous clear: back to reset state
//  load      in   1       load hot position from load_idx
//  load_idx  in   IDXW    position to load; valid range 0..N-1
//  start     in   1       begin a run from the current position
//  en        in   1       step enable, honoured only in RUN
//  dir       in   1       0: p -> (p+1) mod N; 1: p -> (p-1+N) mod N
//  count     out  N       one-hot address; bit p set
//  idx       out  IDXW    binary p, registered with count
//  wrap      out  1       1-cycle pulse: a step returned p to the run origin
//  busy      out  1       high in RUN
//  done      out  1       high in DONE, held until start/clr/load
// BEHAVIOUR
//  Reset (rst_n=0), asynchronous:
//   - count = 1<<(N-1), idx = N-1, origin = N-1, pass_cnt = 0.
//   - wrap = 0, busy = 0, done = 0, state = IDLE.
//  FSM states: IDLE -> RUN -> DONE.
//   - IDLE/DONE, start=1: go to RUN next edge; origin <= p; pass_cnt <= 0; done <= 0.
//   - RUN, en=1: step one position per edge in direction dir; count and idx update together.
//   - RUN, en=0: hold.
//   - RUN, step lands on origin: wrap=1 on the next cycle, aligned with count showing origin;
//     pass_cnt += 1.
//   - Pass completes with pass_cnt+1 == PASSES: go to DONE in the same edge; busy=0, done=1.
//   - DONE: en ignored; count holds origin.
//  Priority per edge: clr > load > start > step.
//   - clr: same values as reset, synchronous.
//   - load with load_idx < N: p <= load_idx, state -> IDLE, pass_cnt = 0, done = 0.
//   - load with load_idx >= N: ignored entirely; no state change.
//   - start while in RUN: ignored; the run continues.
//  dir may change on any cycle mid-run.
//   - A pass is counted whenever p re-enters origin by stepping, in either direction.
//   - Reversing one step then back counts as a pass when it lands on origin.
//  Latency: 1 edge from en to new count; wrap/done visible on the edge that lands on origin.
//  Stepping outside RUN is impossible: no input combination advances count in IDLE/DONE.
//  Reset asserted mid-run: all outputs return to reset values immediately, without waiting for clk.
//  Widths:
//   - pass_cnt is 8-bit.
//   - idx arithmetic is mod N; never emit idx >= N.
//   - count always equals 1<<idx.
// CONFIGURATION
//  ONEHOT_CHECK_EN defined:
//   - Adds output port onehot_err (1 bit, reset 0).
//   - onehot_err is registered and sticky. It sets when count is not exactly one-hot,
//     count != 1<<idx, or a load with load_idx >= N is seen.
//   - Cleared only by rst_n or clr.
//  ONEHOT_CHECK_EN undefined:
//   - Port absent, no checker logic.
//   - Out-of-range loads are still silently ignored.
// TESTING
//  1. Reset, N=15, start, en=1, dir=0 for 15 cycles:
//     count 0x4000 -> 0x0001 -> 0x0002 ... -> 0x4000; wrap=1 on cycle 15; done=1; busy=0.
//  2. PASSES=2, dir=1, start, en=1:
//     idx 14,13..0,14 gives wrap#1 with done=0; 15 more steps give wrap#2 with done=1;
//     further en leaves count=0x4000.
//  3. load_idx=5, then start; en toggled 1,0,1:
//     idx 5 -> 6 -> 6 -> 7; en=0 holds; origin=5; wrap only when idx returns to 5.
//  4. load_idx=15 (out of range) in IDLE:
//     count unchanged; with ONEHOT_CHECK_EN, onehot_err=1 until clr.
//  5. Same-edge clr+load+start during RUN:
//     clr wins; count=0x4000, IDLE.
//     Async rst_n pulse mid-run: outputs reset with no clk edge.
//  6. RUN at idx=0, toggle dir 0,1 alternately with en=1:
//     idx 0,1,0,1...; no wrap while origin=14; pass_cnt stays 0.

Source files
------------

// File: rtl/onehot_addr_sequencer.sv
// One-hot write-address ring sequencer with pass counting and run FSM.
// Optional ONEHOT_CHECK_EN adds a sticky onehot_err integrity flag.
module onehot_addr_sequencer #(
  parameter int N      = 15,
  parameter int PASSES = 1,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [IDXW-1:0] load_idx,
  input  logic            start,
  input  logic            en,
  input  logic            dir,
  output logic [N-1:0]    count,
  output logic [IDXW-1:0] idx,
  output logic            wrap,
  output logic            busy,
`ifdef ONEHOT_CHECK_EN
  output logic            onehot_err,
`endif
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW:0]   NW   = (IDXW + 1)'(N);
  localparam logic [N-1:0]    ONE  = N'(1);
  localparam logic [7:0]      PMAX = 8'(PASSES);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_d, origin_q, origin_d, nxt;
  logic [N-1:0]    count_d;
  logic [7:0]      pcnt_q, pcnt_d;
  logic            wrap_d;
  logic            load_ok, start_ok;

  assign load_ok  = load && ({1'b0, load_idx} < NW);
  assign start_ok = start && (state_q != RUN);

  // Neighbour on the ring, wrapping mod N in both directions
  always_comb begin
    nxt = idx;
    if (dir) nxt = (idx == '0) ? LAST : idx - IDXW'(1);
    else     nxt = (idx == LAST) ? '0 : idx + IDXW'(1);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx;
    origin_d = origin_q;
    pcnt_d   = pcnt_q;
    wrap_d   = 1'b0;
    if (clr) begin
      state_d  = IDLE;
      idx_d    = LAST;
      origin_d = LAST;
      pcnt_d   = '0;
    end else if (load_ok) begin
      state_d = IDLE;
      idx_d   = load_idx;
      pcnt_d  = '0;
    end else if (start_ok) begin
      state_d  = RUN;
      origin_d = idx;
      pcnt_d   = '0;
    end else if (state_q == RUN && en) begin
      idx_d = nxt;
      if (nxt == origin_q) begin
        wrap_d = 1'b1;
        pcnt_d = pcnt_q + 8'd1;
        if (pcnt_q + 8'd1 == PMAX) state_d = DONE;
      end
    end
    count_d = ONE << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx      <= LAST;
      count    <= ONE << LAST;
      origin_q <= LAST;
      pcnt_q   <= '0;
      wrap     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx      <= idx_d;
      count    <= count_d;
      origin_q <= origin_d;
      pcnt_q   <= pcnt_d;
      wrap     <= wrap_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef ONEHOT_CHECK_EN
  logic bad, err_d;

  assign bad = ($countones(count) != 1)
            || (count != (ONE << idx))
            || (load && !load_ok);

  always_comb begin
    err_d = onehot_err | bad;
    if (clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_err <= 1'b0;
    else        onehot_err <= err_d;
  end
`endif

endmodule
